// File: rtl/revive_instr_align.sv
// Halfword prefetch/alignment buffer between the fetch bus and the RVC decompressor.
// Latency: an accepted word is visible in the instruction window on the next cycle.
// Backpressure: fetch_ready drops when fewer than two halfwords are free; a pop never raises ready in the same cycle.
module revive_instr_align #(
    parameter int DEPTH_HW = 6,
    parameter int W_LEVEL  = $clog2(DEPTH_HW + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        fetch_data,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic               flush,
    input  logic               flush_unaligned,
    output logic [31:0]        instr_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               instr_is_32bit,
    output logic [W_LEVEL-1:0] level
);

    // A full fetch word needs two free halfwords; the check uses the pre-pop level only.
    localparam logic [W_LEVEL-1:0] PUSH_LIMIT = W_LEVEL'(DEPTH_HW - 2);
    localparam logic [W_LEVEL-1:0] LVL_ONE    = W_LEVEL'(1);
    localparam logic [W_LEVEL-1:0] LVL_TWO    = W_LEVEL'(2);

    logic [15:0]        hw_q [DEPTH_HW];
    logic [15:0]        hw_d [DEPTH_HW];
    logic [15:0]        ext  [DEPTH_HW + 2];
    logic [W_LEVEL-1:0] level_q;
    logic               skip_lo;

    logic               is32;
    logic               push;
    logic               pop;
    logic [W_LEVEL-1:0] pop_n;
    logic [W_LEVEL-1:0] push_n;
    logic [W_LEVEL-1:0] rem;
    logic [W_LEVEL-1:0] level_d;
    logic [15:0]        first_hw;

    // Length decode looks only at the head parcel; reserved >32-bit encodings fall into the 32-bit case.
    assign is32           = (hw_q[0][1:0] == 2'b11);
    assign instr_is_32bit = is32;
    assign instr_data     = {(level_q >= LVL_TWO) ? hw_q[1] : 16'h0000, hw_q[0]};
    assign level          = level_q;

    assign fetch_ready = !rst && (level_q <= PUSH_LIMIT);
    assign instr_valid = !rst && (level_q != '0) && (!is32 || (level_q >= LVL_TWO));

    // Flush wins over both push and pop; a word offered during flush is taken and thrown away.
    assign push = fetch_valid && fetch_ready && !flush;
    assign pop  = instr_valid && instr_ready && !flush;

    assign pop_n    = pop  ? (is32    ? LVL_TWO : LVL_ONE) : '0;
    assign push_n   = push ? (skip_lo ? LVL_ONE : LVL_TWO) : '0;
    assign rem      = level_q - pop_n;
    assign level_d  = rem + push_n;
    // After an unaligned jump the low halfword of the first word precedes the target.
    assign first_hw = skip_lo ? fetch_data[31:16] : fetch_data[15:0];

    // Zero-padded view of storage so a two-halfword shift never indexes past the end.
    always_comb begin
        for (int i = 0; i < DEPTH_HW; i++) begin
            ext[i] = hw_q[i];
        end
        ext[DEPTH_HW]     = 16'h0000;
        ext[DEPTH_HW + 1] = 16'h0000;
    end

    // Next storage: shift out the popped parcels, then append new parcels after the survivors.
    always_comb begin
        for (int i = 0; i < DEPTH_HW; i++) begin
            if (pop && is32) begin
                hw_d[i] = ext[i + 2];
            end else if (pop) begin
                hw_d[i] = ext[i + 1];
            end else begin
                hw_d[i] = hw_q[i];
            end
            if (push && (W_LEVEL'(i) == rem)) begin
                hw_d[i] = first_hw;
            end
            if (push && !skip_lo && (W_LEVEL'(i) == rem + LVL_ONE)) begin
                hw_d[i] = fetch_data[31:16];
            end
        end
    end

    // Level and skip flag: reset/flush empty the buffer, otherwise pop-then-push accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            skip_lo <= 1'b0;
        end else if (flush) begin
            level_q <= '0;
            skip_lo <= flush_unaligned;
        end else begin
            level_q <= level_d;
            if (push) begin
                skip_lo <= 1'b0;
            end
        end
    end

    // Parcel storage; entries at or above level are never presented as valid, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH_HW; i++) begin
            hw_q[i] <= hw_d[i];
        end
    end

endmodule

// File: tb/tb_revive_instr_align.sv
// Bench for revive_instr_align: scenario tasks with a scoreboard of expected instruction windows.
module tb_revive_instr_align;

    localparam int DEPTH_HW = 6;
    localparam int W_LEVEL  = $clog2(DEPTH_HW + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        fetch_data = '0;
    logic               fetch_valid = 1'b0;
    logic               fetch_ready;
    logic               flush = 1'b0;
    logic               flush_unaligned = 1'b0;
    logic [31:0]        instr_data;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic               instr_is_32bit;
    logic [W_LEVEL-1:0] level;

    typedef struct packed {
        logic [31:0] data;
        logic        is32;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    revive_instr_align #(.DEPTH_HW(DEPTH_HW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_data     (fetch_data),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .flush          (flush),
        .flush_unaligned(flush_unaligned),
        .instr_data     (instr_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_is_32bit (instr_is_32bit),
        .level          (level)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h0010_0093;
        tick(); tick();
        checks++;
        if (fetch_ready !== 1'b0 || instr_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_held got fr=%b v=%b lvl=%0d want fr=0 v=0 lvl=0", fetch_ready, instr_valid, level);
        end
        rst = 1'b0; fetch_valid = 1'b0;
        tick();
        checks++;
        if (fetch_ready !== 1'b1 || instr_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle got fr=%b v=%b lvl=%0d want fr=1 v=0 lvl=0", fetch_ready, instr_valid, level);
        end
    endtask

    task automatic test_aligned();
        instr_ready = 1'b1;
        fetch_valid = 1'b1; fetch_data = 32'h0010_0093; exp_q.push_back('{32'h0010_0093, 1'b1});
        tick();
        e = exp_q.pop_front(); checks++;
        if (!instr_valid || instr_data !== e.data || instr_is_32bit !== e.is32) begin
            errors++;
            $display("FAIL aligned_1 got v=%b d=%h l32=%b want v=1 d=%h l32=%b", instr_valid, instr_data, instr_is_32bit, e.data, e.is32);
        end
        fetch_data = 32'h0020_0113; exp_q.push_back('{32'h0020_0113, 1'b1});
        tick();
        e = exp_q.pop_front(); checks++;
        if (!instr_valid || instr_data !== e.data || instr_is_32bit !== e.is32) begin
            errors++;
            $display("FAIL aligned_2 got v=%b d=%h l32=%b want v=1 d=%h l32=%b", instr_valid, instr_data, instr_is_32bit, e.data, e.is32);
        end
        fetch_valid = 1'b0;
        tick();
        checks++;
        if (level !== 3'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL aligned_drain got lvl=%0d v=%b want lvl=0 v=0", level, instr_valid);
        end
    endtask

    task automatic test_straddle();
        instr_ready = 1'b1;
        fetch_valid = 1'b1; fetch_data = 32'h0093_4505; exp_q.push_back('{32'h0093_4505, 1'b0});
        tick();
        e = exp_q.pop_front(); checks++;
        if (!instr_valid || instr_data !== e.data || instr_is_32bit !== e.is32) begin
            errors++;
            $display("FAIL straddle_c16 got v=%b d=%h l32=%b want v=1 d=%h l32=%b", instr_valid, instr_data, instr_is_32bit, e.data, e.is32);
        end
        fetch_valid = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || level !== 3'd1 || instr_data !== 32'h0000_0093) begin
            errors++;
            $display("FAIL straddle_wait got v=%b lvl=%0d d=%h want v=0 lvl=1 d=00000093", instr_valid, level, instr_data);
        end
        fetch_valid = 1'b1; fetch_data = 32'h0000_0010;
        exp_q.push_back('{32'h0010_0093, 1'b1});
        exp_q.push_back('{32'h0000_0000, 1'b0});
        tick();
        e = exp_q.pop_front(); checks++;
        if (!instr_valid || instr_data !== e.data || instr_is_32bit !== e.is32) begin
            errors++;
            $display("FAIL straddle_i32 got v=%b d=%h l32=%b want v=1 d=%h l32=%b", instr_valid, instr_data, instr_is_32bit, e.data, e.is32);
        end
        fetch_valid = 1'b0;
        tick();
        e = exp_q.pop_front(); checks++;
        if (!instr_valid || instr_data !== e.data || instr_is_32bit !== e.is32 || level !== 3'd1) begin
            errors++;
            $display("FAIL straddle_zero got v=%b d=%h l32=%b lvl=%0d want v=1 d=%h l32=%b lvl=1", instr_valid, instr_data, instr_is_32bit, level, e.data, e.is32);
        end
        tick();
        checks++;
        if (level !== 3'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL straddle_drain got lvl=%0d v=%b want lvl=0 v=0", level, instr_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p [8];
        p[0] = 16'h0001; p[1] = 16'h0005; p[2] = 16'h0009; p[3] = 16'h000D;
        p[4] = 16'h0011; p[5] = 16'h0015; p[6] = 16'h0019; p[7] = 16'h001D;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{{(i < 7) ? p[i + 1] : 16'h0000, p[i]}, 1'b0});
        end
        instr_ready = 1'b0; fetch_valid = 1'b1;
        fetch_data = {p[1], p[0]}; tick();
        fetch_data = {p[3], p[2]}; tick();
        checks++;
        if (level !== 3'd4 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_level4 got lvl=%0d fr=%b want lvl=4 fr=1", level, fetch_ready);
        end
        fetch_data = {p[5], p[4]}; tick();
        fetch_data = {p[7], p[6]}; tick();
        checks++;
        if (level !== 3'd6 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got lvl=%0d fr=%b want lvl=6 fr=0", level, fetch_ready);
        end
        instr_ready = 1'b1;
        e = exp_q.pop_front(); checks++;
        if (!instr_valid || instr_data !== e.data || instr_is_32bit !== e.is32) begin
            errors++;
            $display("FAIL bp_pop0 got v=%b d=%h want v=1 d=%h", instr_valid, instr_data, e.data);
        end
        tick();
        checks++;
        if (level !== 3'd5 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_level5 got lvl=%0d fr=%b want lvl=5 fr=0", level, fetch_ready);
        end
        e = exp_q.pop_front(); checks++;
        if (!instr_valid || instr_data !== e.data || instr_is_32bit !== e.is32) begin
            errors++;
            $display("FAIL bp_pop1 got v=%b d=%h want v=1 d=%h", instr_valid, instr_data, e.data);
        end
        tick();
        checks++;
        if (level !== 3'd4 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_reopen got lvl=%0d fr=%b want lvl=4 fr=1", level, fetch_ready);
        end
        // The held word is accepted now, alongside a pop; then drain everything.
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (instr_valid) begin
                e = exp_q.pop_front(); checks++;
                if (instr_data !== e.data || instr_is_32bit !== e.is32) begin
                    errors++;
                    $display("FAIL bp_drain got d=%h l32=%b want d=%h l32=%b", instr_data, instr_is_32bit, e.data, e.is32);
                end
            end
            tick();
            fetch_valid = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0 || level !== 3'd0) begin
            errors++;
            $display("FAIL bp_timeout got left=%0d lvl=%0d want left=0 lvl=0", exp_q.size(), level);
            exp_q.delete();
        end
    endtask

    task automatic test_flush_unaligned();
        instr_ready = 1'b0; fetch_valid = 1'b1;
        fetch_data = 32'h0005_0001; tick();
        fetch_data = 32'h000D_0009; tick();
        flush = 1'b1; flush_unaligned = 1'b1; fetch_data = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (level !== 3'd0 || instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got lvl=%0d v=%b fr=%b want lvl=0 v=0 fr=1", level, instr_valid, fetch_ready);
        end
        flush = 1'b0; flush_unaligned = 1'b0; fetch_data = 32'h1111_2222;
        tick();
        checks++;
        if (level !== 3'd1 || instr_data !== 32'h0000_1111 || instr_valid !== 1'b1 || instr_is_32bit !== 1'b0) begin
            errors++;
            $display("FAIL flush_target got lvl=%0d d=%h v=%b want lvl=1 d=00001111 v=1", level, instr_data, instr_valid);
        end
        fetch_valid = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h3333_4444;
        tick();
        checks++;
        if (level !== 3'd2 || instr_data !== 32'h3333_4444) begin
            errors++;
            $display("FAIL flush_skip_cleared got lvl=%0d d=%h want lvl=2 d=33334444", level, instr_data);
        end
        // A second flush overwrites a pending unaligned skip.
        fetch_valid = 1'b0; flush = 1'b1; flush_unaligned = 1'b1; tick();
        flush_unaligned = 1'b0; tick();
        flush = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h0007_0001;
        tick();
        checks++;
        if (level !== 3'd2 || instr_data !== 32'h0007_0001) begin
            errors++;
            $display("FAIL flush_overwrite got lvl=%0d d=%h want lvl=2 d=00070001", level, instr_data);
        end
        fetch_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
    endtask

    task automatic test_flush_collision();
        instr_ready = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h0005_0001;
        tick();
        instr_ready = 1'b1; flush = 1'b1; flush_unaligned = 1'b0; fetch_data = 32'h000D_0009;
        tick();
        checks++;
        if (level !== 3'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL collide_flush got lvl=%0d v=%b want lvl=0 v=0", level, instr_valid);
        end
        flush = 1'b0; instr_ready = 1'b0; fetch_data = 32'h0015_0011;
        tick();
        checks++;
        if (level !== 3'd2 || instr_data !== 32'h0015_0011) begin
            errors++;
            $display("FAIL collide_after got lvl=%0d d=%h want lvl=2 d=00150011", level, instr_data);
        end
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        flush = 1'b1; flush_unaligned = 1'b1; tick();
        flush = 1'b0; flush_unaligned = 1'b0;
        rst = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h0019_0015;
        tick();
        checks++;
        if (fetch_ready !== 1'b0 || instr_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL midreset_held got fr=%b v=%b lvl=%0d want fr=0 v=0 lvl=0", fetch_ready, instr_valid, level);
        end
        rst = 1'b0; fetch_valid = 1'b0; tick();
        fetch_valid = 1'b1; fetch_data = 32'h0009_0005;
        tick();
        checks++;
        if (level !== 3'd2 || instr_data !== 32'h0009_0005) begin
            errors++;
            $display("FAIL midreset_after got lvl=%0d d=%h want lvl=2 d=00090005", level, instr_data);
        end
        fetch_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_straddle();
        test_backpressure();
        test_flush_unaligned();
        test_flush_collision();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/revive_instr_align.md
Name: revive_instr_align

Overview:
- Halfword-granular prefetch and alignment buffer that sits between the instruction fetch bus and the RVC decompressor in the revive core.
- Accepts aligned 32-bit fetch words and presents a 32-bit window whose bits [15:0] are the next instruction parcel.
- Determines each instruction's length from parcel bits [1:0] and retires 1 or 2 halfwords per handshake.
- Lets 32-bit instructions straddle word boundaries and supports flush to halfword-aligned targets.

Parameters:
- DEPTH_HW, 6, buffer capacity in halfwords; must be even and ≥ 4.
- W_LEVEL, $clog2(DEPTH_HW+1), width of the level count.

Ports:
- clk  in  1  core clock; all state is updated on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_data  in  32  fetched word, little-endian halfword order (hw0 = [15:0]).
- fetch_valid  in  1  fetch_data is valid.
- fetch_ready  out  1  buffer can accept one word this cycle.
- flush  in  1  discard all buffered and in-transfer data.
- flush_unaligned  in  1  qualified by flush; jump target bit 1.
- instr_data  out  32  window: [15:0] = buf[0]; [31:16] = buf[1] if level ≥ 2, else 16'h0.
- instr_valid  out  1  a complete instruction is present in the window.
- instr_ready  in  1  downstream consumes the instruction this cycle.
- instr_is_32bit  out  1  (instr_data[1:0] == 2'b11).
- level  out  W_LEVEL  count of valid halfwords held.

Behaviour:
- Storage: DEPTH_HW halfword registers plus a level count. Entries are shift-style or circular (implementation choice); observable order is strictly FIFO.
- Reset (rst high at clk edge): level = 0, skip_lo = 0.
- While rst is high, fetch_ready = 0 and instr_valid = 0. All outputs are combinational from state.
- fetch_ready = !rst && (level ≤ DEPTH_HW − 2). Pop in the same cycle does not raise ready (no combinational ready path from instr_ready).
- Push occurs when fetch_valid && fetch_ready && !flush:
  - skip_lo = 0: append hw0 then hw1; level += 2.
  - skip_lo = 1: append hw1 only; level += 1; clear skip_lo.
- instr_valid = (level ≥ 1) && (!instr_is_32bit || level ≥ 2). A 32-bit instruction with only its low parcel buffered is not valid.
- Pop occurs when instr_valid && instr_ready: remove 2 halfwords if instr_is_32bit, else 1. instr_ready without instr_valid has no effect.
- Simultaneous push and pop: pop is applied first, then push appends after the remaining entries. New level = level − pop_n + push_n, which never exceeds DEPTH_HW because ready is gated on pre-pop level.
- Flush (highest priority, overrides push and pop in the same cycle):
  - level ← 0.
  - skip_lo ← flush_unaligned.
  - A word presented in the flush cycle is dropped. fetch_ready is unaffected, so the upstream sees an accepted-and-discarded transfer.
  - The upstream presents only target-stream words from the cycle after flush.
- Flush while skip_lo is already set: the new flush_unaligned value overwrites it.
- Reset mid-operation: all buffered data is lost. Behaviour is identical to a flush with flush_unaligned = 0, plus forced-low outputs during reset.
- Lengths other than 16/32-bit (bits [4:2] = 111) are treated as 32-bit. The decompressor flags the instruction as illegal.
- Encoding 16'h0000 is a valid 16-bit parcel (illegal instruction) and is passed through with length 1.

Test Plan:
- Reset then idle: after rst deasserts, level = 0, instr_valid = 0, fetch_ready = 1. With rst held high and fetch_valid = 1, no push occurs.
- Aligned 32-bit stream: push 0x00100093, 0x00200113 with instr_ready = 1 → instr_data = 0x00100093 then 0x00200113. instr_is_32bit = 1 for both; level returns to 0.
- Mixed/straddle: push 0x00934505 (hw0 = 0x4505 c.li, hw1 = 0x0093), then 0x00000010.
  - Expected: 0x4505 with is_32bit = 0 and instr_data[31:16] = 0x0093.
  - Then 32-bit 0x00100093 straddling the word boundary. valid stays low until the second word is pushed.
- Unaligned flush: level = 4, flush = 1, flush_unaligned = 1, with a word presented in the same cycle.
  - Next cycle: level = 0, and the word presented in the flush cycle is dropped.
  - Push 0x1111_2222 → level = 1, instr_data = 0x00001111.
- Backpressure/full: DEPTH_HW = 6, instr_ready = 0, push three words → level = 6, fetch_ready = 0.
  - Pop one 16-bit instruction → level = 5, fetch_ready still 0 (5 > DEPTH_HW − 2).
  - Pop one more 16-bit → level = 4, fetch_ready = 1.
- Simultaneous push, pop and flush: level = 2, fetch_valid and instr_ready high, flush = 1 → next level = 0, no data retained.
